// File: rtl/shiftadd_mult_32_pkg.sv
// -----------------------------------------------------------------------------
// shiftadd_mult_32_pkg
// Shared definitions for the radix-2 Booth shift/add multiplier:
//   - state_t : controller state encoding (IDLE / BUSY / DONE)
//   - WIDTH   : operand and result width (32)
//   - STEPS   : number of Booth iterations per multiply (one per multiplier bit)
//   - CNT_W   : width of the iteration counter
// -----------------------------------------------------------------------------
package shiftadd_mult_32_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shiftadd_mult_32_if.sv
// -----------------------------------------------------------------------------
// shiftadd_mult_32_if
// Request/response bundle of the multiplier.
//   ctrl_mult       : start pulse (master -> slave)
//   data_operandA   : multiplicand, two's complement (master -> slave)
//   data_operandB   : multiplier, two's complement (master -> slave)
//   data_result     : low WIDTH bits of the signed product (slave -> master)
//   data_exception  : signed overflow of the product (slave -> master)
//   data_resultRDY  : one-cycle result-valid pulse (slave -> master)
//   busy            : operation in progress (slave -> master)
// -----------------------------------------------------------------------------
interface shiftadd_mult_32_if;
    import shiftadd_mult_32_pkg::*;

    logic             ctrl_mult;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_mult, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_mult, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/shiftadd_mult_32_step_counter.sv
// -----------------------------------------------------------------------------
// mult_step_counter
// Iteration counter for the Booth multiplier.
//   clk      : clock, rising edge
//   srst     : synchronous active-high reset, clears the count
//   i_clear  : synchronous clear (new operation accepted)
//   i_enable : advance by one
//   o_tc     : terminal count, high while the count equals STEPS-1
// -----------------------------------------------------------------------------
module mult_step_counter
    import shiftadd_mult_32_pkg::*;
(
    input  logic clk,
    input  logic srst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = (r_count == CNT_W'(STEPS - 1));

endmodule

// File: rtl/shiftadd_mult_32.sv
// -----------------------------------------------------------------------------
// shiftadd_mult_32
// Sequential signed 32x32 multiplier using radix-2 Booth recoding, one
// multiplier bit per clock. A start accepted at edge k produces a one-cycle
// data_resultRDY pulse during the cycle after edge k+33.
//   clock : clock, rising edge
//   reset : synchronous active-high reset (wins over ctrl_mult)
//   bus   : shiftadd_mult_32_if.slave (start, operands, result, flags, busy)
// -----------------------------------------------------------------------------
module shiftadd_mult_32 #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    shiftadd_mult_32_if.slave bus
);
    import shiftadd_mult_32_pkg::*;

    localparam int ACC_W = 2 * WIDTH;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_mcand;     // sign-extended multiplicand, shifted left each step
    logic [WIDTH-1:0]   r_mplier;    // multiplier, shifted right so bit 0 is the current bit
    logic               r_prev;      // previously consumed multiplier bit
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    logic               w_start;
    logic               w_cnt_en;
    logic               w_cnt_tc;
    logic [1:0]         w_pair;
    logic [ACC_W-1:0]   w_acc_step;
    logic               w_ovf;

    assign w_start  = bus.ctrl_mult;
    // A start in any state (including mid-BUSY) restarts the count, so the
    // counter only advances on BUSY cycles that are not being restarted.
    assign w_cnt_en = (r_state == ST_BUSY) && !w_start;

    mult_step_counter u_step_counter (
        .clk      (clock),
        .srst     (reset),
        .i_clear  (w_start),
        .i_enable (w_cnt_en),
        .o_tc     (w_cnt_tc)
    );

    // Booth pair {current bit, previous bit}: 01 adds, 10 subtracts.
    // Full 64-bit arithmetic keeps the subtract exact for 0x80000000.
    assign w_pair = {r_mplier[0], r_prev};

    always_comb begin
        w_acc_step = r_acc;
        case (w_pair)
            2'b01:   w_acc_step = r_acc + r_mcand;
            2'b10:   w_acc_step = r_acc - r_mcand;
            default: w_acc_step = r_acc;
        endcase
    end

    // Overflow: the upper half is not the sign-extension of the lower half.
    assign w_ovf = (r_acc[ACC_W-1:WIDTH] != {WIDTH{r_acc[WIDTH-1]}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prev   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;

            // DONE publishes the result even if a new start arrives in the
            // same cycle; the start is then accepted below.
            if (r_state == ST_DONE) begin
                r_rdy    <= 1'b1;
                r_result <= r_acc[WIDTH-1:0];
                r_exc    <= w_ovf;
            end

            if (w_start) begin
                r_state  <= ST_BUSY;
                r_busy   <= 1'b1;
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                r_mplier <= bus.data_operandB;
                r_prev   <= 1'b0;
            end else begin
                case (r_state)
                    ST_BUSY: begin
                        r_acc    <= w_acc_step;
                        r_mcand  <= {r_mcand[ACC_W-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        r_prev   <= r_mplier[0];
                        if (w_cnt_tc) begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;

endmodule

// File: doc/shiftadd_mult_32.md
SHIFTADD_MULT_32 -- requirements
Module: shiftadd_mult_32

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ctrl_mult  input  1  start pulse; sampled each rising edge.
REQ-005 Port: data_operandA  input  32  multiplicand, two's complement; sampled only on an accepted start.
REQ-006 Port: data_operandB  input  32  multiplier, two's complement; sampled only on an accepted start.
REQ-007 Port: data_result  output  32  low 32 bits of the signed product.
REQ-008 Port: data_exception  output  1  signed overflow flag: the 64-bit product is not the sign-extension of data_result.
REQ-009 Port: data_resultRDY  output  1  one-cycle pulse; data_result and data_exception are valid.
REQ-010 Port: busy  output  1  high while an iteration is in progress.

Function
REQ-011 The block SHALL have states IDLE, BUSY and DONE.
REQ-012 IDLE -> BUSY when ctrl_mult=1; the block latches both operands and clears the 64-bit accumulator and the 6-bit step counter.
REQ-013 In BUSY, each cycle SHALL consume one multiplier bit, LSB first, with radix-2 Booth recoding against the previously consumed bit (initially 0).
REQ-014 Booth pair 01 SHALL add the multiplicand, pair 10 SHALL subtract it, and pairs 00/11 SHALL make no change.
REQ-015 The add/subtract term SHALL be the multiplicand sign-extended to 64 bits and left-shifted by one bit per step (running shift register).
REQ-016 After the 32nd BUSY cycle the block SHALL enter DONE for exactly one cycle.
REQ-017 In DONE, data_resultRDY=1, data_result=acc[31:0], and data_exception=1 iff acc[63:32] != {32{acc[31]}}.
REQ-018 Latency: start sampled at edge k -> data_resultRDY high during the cycle after edge k+33.
REQ-019 DONE -> IDLE unconditionally.
REQ-020 data_result and data_exception SHALL hold their last values until the next DONE.
REQ-021 busy SHALL be 1 in BUSY and DONE, else 0.
REQ-022 ctrl_mult=1 during BUSY SHALL restart: discard the current operation, latch the new operands, reset the counter, and produce no data_resultRDY for the abandoned operation.
REQ-023 ctrl_mult=1 in DONE SHALL still emit the pulse and SHALL be accepted as a start, giving DONE -> BUSY.
REQ-024 The Booth subtract SHALL be exact for multiplicand 0x80000000, using 64-bit arithmetic with no truncation.
REQ-025 Operand inputs SHALL be ignored outside an accepted start.

Reset
REQ-026 reset=1 SHALL force IDLE, clear the accumulator, shift register and counter, and drive data_result=0, data_exception=0, data_resultRDY=0, busy=0 on the next edge.
REQ-027 reset SHALL take priority over ctrl_mult in every state.
REQ-028 reset mid-BUSY SHALL abort with no data_resultRDY pulse.

Structure
REQ-029 The shared package SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), WIDTH=32, and STEPS=32.
REQ-030 One sub-module, mult_step_counter, SHALL provide a 6-bit synchronous counter with clear, enable and terminal-count (==31) outputs.
REQ-031 The accumulator and shift paths SHALL be 64-bit; the counter is the only other sequential sub-block.

Verification
REQ-032 3 x 4 started at edge 0 -> data_resultRDY pulse after edge 33, data_result=0x0000000C, data_exception=0.
REQ-033 -5 x 7 -> data_result=0xFFFFFFDD, data_exception=0; 0x7FFFFFFF x 1 -> 0x7FFFFFFF, data_exception=0.
REQ-034 0x00010000 x 0x00010000 -> data_result=0x00000000, data_exception=1; 0x80000000 x 0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
REQ-035 Start 6 x 6, then at cycle 10 start 2 x 9 -> single pulse 33 cycles after the second start with result 0x00000012.
REQ-036 reset asserted at cycle 15 of BUSY -> all outputs 0 next edge, no pulse; a following start 1 x 1 -> result 0x00000001.
REQ-037 ctrl_mult held high continuously -> the block restarts every cycle and emits no pulse until ctrl_mult is released.
